serial_addsub: RTL and testbench

Bit-serial adder/subtractor that computes one result bit per clock through a single full-adder cell and a carry flip-flop. Operands are latched on a start handshake. After WIDTH cycles the block presents a registered sum, carry/borrow, signed-overflow and zero flags, with a one-cycle done pulse. It is the sequential, area-minimal counterpart to the 4-bit ripple-carry adder: same operand and carry semantics, plus subtraction, for datapaths that trade latency for a single adder cell.

---
 rtl/serial_addsub.sv | 95 +++++++++
 tb/tb_serial_addsub.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop produce one
// result bit per clock, LSB first, into a shadow register published on completion.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] a, b, shadow;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s, cnext, last;
  logic [WIDTH-1:0] fin;

  // Single full-adder cell working on the current LSBs.
  assign s     = a[0] ^ b[0] ^ carry;
  assign cnext = (a[0] & b[0]) | (a[0] & carry) | (b[0] & carry);
  assign last  = (cnt == CW'(WIDTH - 1));
  assign fin   = {s, shadow[WIDTH-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Subtraction is folded into the load: invert B and the borrow-in once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a        <= '0;
      b        <= '0;
      shadow   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a      <= in1;
          b      <= in2 ^ {WIDTH{sub}};
          carry  <= cin ^ sub;
          cnt    <= '0;
          shadow <= '0;
        end
        RUN: begin
          a      <= a >> 1;
          b      <= b >> 1;
          carry  <= cnext;
          shadow <= fin;
          cnt    <= cnt + 1'b1;
          // On the MSB cycle `carry` is still the carry into the MSB.
          if (last) begin
            sum      <= fin;
            cout     <= cnext;
            overflow <= carry ^ cnext;
            zero     <= (fin == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub with an arithmetic reference model checked
// every cycle, plus literal expectations on each directed operation.
module tb_serial_addsub;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clock(clock), .resetn(resetn), .start(start), .sub(sub),
    .in1(in1), .in2(in2), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: rem counts edges left until the block is idle again.
  int           m_rem = 0;
  logic [W-1:0] m_sum = '0, e_sum;
  logic         m_cout = 0, m_ov = 0, m_zero = 0;
  logic         e_cout, e_ov;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_rem = 0; m_sum = '0; m_cout = 0; m_ov = 0; m_zero = 0;
    end else if (m_rem == 0) begin
      if (start) begin
        int ua, ub, sa, sb, r;
        ua = int'(in1); ub = int'(in2);
        sa = int'($signed(in1)); sb = int'($signed(in2));
        if (!sub) begin
          e_sum  = W'(ua + ub + int'(cin));
          e_cout = (ua + ub + int'(cin)) >= (1 << W);
          r      = sa + sb + int'(cin);
        end else begin
          e_sum  = W'(ua - ub - int'(cin));
          e_cout = ua >= ub + int'(cin);
          r      = sa - sb - int'(cin);
        end
        e_ov  = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
        m_rem = W + 1;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) begin
        m_sum = e_sum; m_cout = e_cout; m_ov = e_ov; m_zero = (e_sum == '0);
      end
    end
  end

  always @(negedge clock) begin
    check("busy", busy, m_rem > 0);
    check("done", done, m_rem == 1);
    check("sum", sum, m_sum);
    check("cout", cout, m_cout);
    check("overflow", overflow, m_ov);
    check("zero", zero, m_zero);
  end

  // Starts one operation and waits (bounded) for done; returns latency in cycles.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, output int lat);
    @(negedge clock);
    in1 = a; in2 = b; cin = c; sub = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (!done && lat <= 10) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic c, input logic s, input logic [W-1:0] xs,
                    input logic xc, input logic xo, input logic xz);
    int lat;
    launch(a, b, c, s, lat);
    check({name, ".latency"}, lat, W);
    check({name, ".sum"}, sum, xs);
    check({name, ".cout"}, cout, xc);
    check({name, ".ovf"}, overflow, xo);
    check({name, ".zero"}, zero, xz);
  endtask

  initial begin
    int lat, t0, t1, ndone;
    repeat (3) @(negedge clock);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sum", sum, 0);
    resetn = 1'b1;

    op("add1", 4'b1101, 4'b1000, 1'b1, 1'b0, 4'b0110, 1, 1, 0);
    op("add2", 4'b1010, 4'b1001, 1'b0, 1'b0, 4'b0011, 1, 1, 0);
    repeat (3) @(negedge clock);
    check("hold.sum", sum, 4'b0011);
    op("sub1", 4'b0101, 4'b0011, 1'b0, 1'b1, 4'b0010, 1, 0, 0);
    op("sub2", 4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 0, 0, 0);

    // Back-to-back with start held high: second operands swapped in after first done.
    @(negedge clock);
    in1 = 4'b0111; in2 = 4'b0111; cin = 0; sub = 1; start = 1;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!done && lat < 12);
    t0 = cyc;
    check("b2b1.sum", sum, 4'b0000);
    check("b2b1.zero", zero, 1);
    check("b2b1.cout", cout, 1);
    in1 = 4'b1000; in2 = 4'b0001;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!done && lat < 12);
    t1 = cyc;
    start = 0;
    check("b2b2.sum", sum, 4'b0111);
    check("b2b2.ovf", overflow, 1);
    check("b2b2.cout", cout, 1);
    check("b2b.gap", t1 - t0, W + 2);

    // Start pulse and operand changes during RUN must be ignored.
    @(negedge clock);
    in1 = 4'b0011; in2 = 4'b0001; cin = 0; sub = 0; start = 1;
    @(negedge clock);
    start = 0;
    @(negedge clock);
    in1 = 4'b1111; in2 = 4'b1111; cin = 1; sub = 1; start = 1;
    @(negedge clock);
    start = 0; in1 = 4'b1010;
    lat = 2;
    while (!done && lat <= 10) begin @(negedge clock); lat++; end
    check("prot.latency", lat, W);
    check("prot.sum", sum, 4'b0100);
    check("prot.cout", cout, 0);
    @(negedge clock);
    check("prot.idle", busy, 0);

    // Asynchronous reset two cycles into RUN.
    @(negedge clock);
    in1 = 4'b0110; in2 = 4'b0101; cin = 0; sub = 0; start = 1;
    @(negedge clock);
    start = 0;
    repeat (2) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.sum", sum, 0);
    check("arst.flags", {cout, overflow, zero}, 0);
    @(negedge clock);
    resetn = 1'b1;
    ndone = 0;
    repeat (8) begin @(negedge clock); if (done) ndone++; end
    check("arst.nodone", ndone, 0);
    op("post", 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0010, 0, 0, 0);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
